periph_bus_ctrl: RTL and testbench

Peripheral bus controller that sits between the CPU's memory-mapped I/O port and the 8-bit chip-select peripheral drivers (LED, switch, display and similar). It decodes the CPU address into a one-hot active-low chip select. It serializes 1-, 2- or 4-byte CPU accesses into single-byte strobes on the shared peripheral bus, captures read data from the selected driver's `miso`, and reports completion or decode error back to the CPU.

---
 rtl/periph_bus_ctrl_if.sv | 31 +++
 rtl/periph_bus_ctrl.sv | 151 +++++++++++++++
 tb/tb_periph_bus_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/periph_bus_ctrl_if.sv
// CPU-side request/response signals and the shared 8-bit peripheral bus
// bundled for the peripheral bus controller.
interface periph_bus_ctrl_if #(
  parameter int NDEV = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [7:0]        cpu_addr;
  logic [1:0]        cpu_size;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_busy;
  logic              cpu_done;
  logic              cpu_err;
  logic [NDEV-1:0]   cs_n;
  logic              rw;
  logic [7:0]        mosi;
  logic [3:0]        dev_addr;
  logic [NDEV*8-1:0] miso;

  // The controller is the slave of the CPU port and drives the peripheral bus.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_size, cpu_wdata, miso,
    output cpu_rdata, cpu_busy, cpu_done, cpu_err, cs_n, rw, mosi, dev_addr
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_size, cpu_wdata, miso,
    input  cpu_rdata, cpu_busy, cpu_done, cpu_err, cs_n, rw, mosi, dev_addr
  );
endinterface

// File: rtl/periph_bus_ctrl.sv
// Peripheral bus controller: decodes CPU MMIO accesses to one-hot active-low
// chip selects and serializes 1/2/4-byte accesses into byte strobes.
module periph_bus_ctrl #(
  parameter int NDEV = 8
) (
  input  logic              sck,
  input  logic              rst,
  periph_bus_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_reg;
  logic            we_reg;
  logic [3:0]      slot_reg;
  logic [1:0]      size_reg;
  logic [31:0]     wdata_reg;
  logic [1:0]      k_reg;
  logic [31:0]     rdata_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            err_reg;
  logic [NDEV-1:0] cs_n_reg;
  logic            rw_reg;
  logic [7:0]      mosi_reg;
  logic [3:0]      dev_addr_reg;

  logic [NDEV-1:0] slot_onehot;
  logic [7:0]      miso_byte [NDEV];
  logic [7:0]      miso_sel;
  logic [1:0]      last_k;
  logic            decode_err;

  function automatic logic [7:0] wbyte(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    wbyte = w[7:0];
      2'd1:    wbyte = w[15:8];
      2'd2:    wbyte = w[23:16];
      default: wbyte = w[31:24];
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NDEV; gi++) begin : g_slot
      assign slot_onehot[gi] = (slot_reg == 4'(gi));
      assign miso_byte[gi]   = bus.miso[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    miso_sel = 8'h00;
    for (int i = 0; i < NDEV; i++) begin
      if (slot_reg == 4'(i)) miso_sel = miso_byte[i];
    end
  end

  // Size code 3 never reaches the byte loop, so it has no meaningful last index.
  always_comb begin
    case (size_reg)
      2'd0:    last_k = 2'd0;
      2'd1:    last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  assign decode_err = ({1'b0, bus.cpu_addr[7:4]} >= 5'(NDEV)) || (bus.cpu_size == 2'd3);

  always_ff @(posedge sck) begin
    if (rst) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      slot_reg     <= 4'd0;
      size_reg     <= 2'd0;
      wdata_reg    <= 32'd0;
      k_reg        <= 2'd0;
      rdata_reg    <= 32'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      cs_n_reg     <= '1;
      rw_reg       <= 1'b0;
      mosi_reg     <= 8'd0;
      dev_addr_reg <= 4'd0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.cpu_req) begin
            we_reg    <= bus.cpu_we;
            slot_reg  <= bus.cpu_addr[7:4];
            size_reg  <= bus.cpu_size;
            wdata_reg <= bus.cpu_wdata;
            k_reg     <= 2'd0;
            rdata_reg <= 32'd0;
            busy_reg  <= 1'b1;
            if (decode_err) begin
              err_reg   <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              err_reg      <= 1'b0;
              rw_reg       <= bus.cpu_we;
              mosi_reg     <= bus.cpu_we ? bus.cpu_wdata[7:0] : 8'd0;
              dev_addr_reg <= bus.cpu_addr[3:0];
              state_reg    <= SETUP;
            end
          end
        end
        SETUP: begin
          cs_n_reg  <= ~slot_onehot;
          state_reg <= STROBE;
        end
        STROBE: begin
          cs_n_reg <= '1;
          if (!we_reg) rdata_reg[{k_reg, 3'b000} +: 8] <= miso_sel;
          if (k_reg == last_k) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            // Bus fields for the next byte are set up a full cycle before its strobe.
            k_reg        <= k_reg + 2'd1;
            dev_addr_reg <= dev_addr_reg + 4'd1;
            mosi_reg     <= we_reg ? wbyte(wdata_reg, k_reg + 2'd1) : 8'd0;
            state_reg    <= SETUP;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata = rdata_reg;
  assign bus.cpu_busy  = busy_reg;
  assign bus.cpu_done  = done_reg;
  assign bus.cpu_err   = err_reg;
  assign bus.cs_n      = cs_n_reg;
  assign bus.rw        = rw_reg;
  assign bus.mosi      = mosi_reg;
  assign bus.dev_addr  = dev_addr_reg;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed bench for periph_bus_ctrl: LED-style latch on slot 0, fixed read
// registers on slot 1, strobe and done monitors sampled on the falling edge.
module tb_periph_bus_ctrl;
  localparam int NDEV = 8;

  logic sck = 1'b0;
  logic rst = 1'b1;
  always #5 sck = ~sck;

  periph_bus_ctrl_if #(.NDEV(NDEV)) bus ();

  periph_bus_ctrl #(.NDEV(NDEV)) dut (
    .sck (sck),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [7:0] cs_n;
    logic       rw;
    logic [7:0] mosi;
    logic [3:0] dev_addr;
  } strobe_t;

  strobe_t    slog[$];
  int         done_cnt = 0;
  logic [7:0] led_reg [16];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Device models: slot 0 reads back its latched registers, slot 1 is a fixed
  // register pair, slot 2 returns a poison value to catch wrong-slot reads.
  always_comb begin
    bus.miso = '0;
    bus.miso[7:0]   = led_reg[bus.dev_addr];
    bus.miso[15:8]  = (bus.dev_addr == 4'd3) ? 8'h5A : (bus.dev_addr == 4'd4) ? 8'hC3 : 8'h00;
    bus.miso[23:16] = 8'hEE;
  end

  always @(negedge sck) begin
    if (bus.cs_n != 8'hFF) begin
      slog.push_back('{cs_n: bus.cs_n, rw: bus.rw, mosi: bus.mosi, dev_addr: bus.dev_addr});
      if (bus.cs_n[0] == 1'b0 && bus.rw) led_reg[bus.dev_addr] <= bus.mosi;
    end
    if (bus.cpu_done) done_cnt++;
  end

  // Runs one access and returns the cycle latency (request cycle counted as 1).
  task automatic do_access(input logic we, input logic [7:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata, input int inject_at, output int lat);
    int cnt;
    slog.delete();
    @(posedge sck); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
    bus.cpu_size = size; bus.cpu_wdata = wdata;
    @(posedge sck); #1;
    bus.cpu_req = 1'b0;
    n_checks++;
    if (bus.cpu_busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_accept: got %b want 1", bus.cpu_busy);
    end
    cnt = 0;
    while (bus.cpu_done !== 1'b1 && cnt < 40) begin
      if (cnt == inject_at) begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h13; bus.cpu_size = 2'd0;
      end
      @(posedge sck); #1;
      bus.cpu_req = 1'b0;
      cnt++;
    end
    if (cnt >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: no cpu_done within %0d cycles", cnt);
    end
    lat = cnt + 1;
    $display("access we=%0b addr=%h size=%0d wdata=%h -> lat=%0d rdata=%h err=%0b strobes=%0d",
             we, addr, size, wdata, lat, bus.cpu_rdata, bus.cpu_err, slog.size());
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge sck);
    #1 rst = 1'b0;
    @(posedge sck); #1;
    n_checks++;
    if (bus.cs_n !== 8'hFF || bus.rw !== 1'b0 || bus.mosi !== 8'h00 || bus.dev_addr !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_bus: cs_n=%h rw=%b mosi=%h dev_addr=%h want FF 0 00 0",
               bus.cs_n, bus.rw, bus.mosi, bus.dev_addr);
    end
    n_checks++;
    if (bus.cpu_rdata !== 32'h0 || bus.cpu_busy !== 1'b0 || bus.cpu_done !== 1'b0 || bus.cpu_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cpu: rdata=%h busy=%b done=%b err=%b want 0 0 0 0",
               bus.cpu_rdata, bus.cpu_busy, bus.cpu_done, bus.cpu_err);
    end
  endtask

  task automatic test_single_write;
    int lat;
    do_access(1'b1, 8'h00, 2'd0, 32'h0000_00A5, -1, lat);
    n_checks++;
    if (lat != 3 || bus.cpu_err !== 1'b0) begin
      n_fail++; $display("FAIL single_write_done: lat=%0d err=%b want 3 0", lat, bus.cpu_err);
    end
    n_checks++;
    if (slog.size() != 1 || slog[0] !== strobe_t'({8'hFE, 1'b1, 8'hA5, 4'h0})) begin
      n_fail++; $display("FAIL single_write_strobe: n=%0d first=%h want 1 %h",
                         slog.size(), (slog.size() > 0) ? slog[0] : strobe_t'(0),
                         strobe_t'({8'hFE, 1'b1, 8'hA5, 4'h0}));
    end
    @(posedge sck); #1;
    n_checks++;
    if (led_reg[0] !== 8'hA5) begin
      n_fail++; $display("FAIL single_write_led: got %h want A5", led_reg[0]);
    end
  endtask

  task automatic test_wrap_write;
    int lat;
    strobe_t exp [4];
    exp[0] = '{8'hFB, 1'b1, 8'h11, 4'hE};
    exp[1] = '{8'hFB, 1'b1, 8'h22, 4'hF};
    exp[2] = '{8'hFB, 1'b1, 8'h33, 4'h0};
    exp[3] = '{8'hFB, 1'b1, 8'h44, 4'h1};
    do_access(1'b1, 8'h2E, 2'd2, 32'h4433_2211, -1, lat);
    n_checks++;
    if (lat != 9) begin
      n_fail++; $display("FAIL wrap_write_latency: got %0d want 9", lat);
    end
    n_checks++;
    if (slog.size() != 4) begin
      n_fail++; $display("FAIL wrap_write_count: got %0d want 4", slog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (slog[i] !== exp[i]) begin
          n_fail++; $display("FAIL wrap_write_byte%0d: got %h want %h", i, slog[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_read;
    int lat;
    do_access(1'b0, 8'h13, 2'd1, 32'hFFFF_FFFF, -1, lat);
    n_checks++;
    if (lat != 5 || bus.cpu_rdata !== 32'h0000_C35A || bus.cpu_err !== 1'b0) begin
      n_fail++; $display("FAIL read2_data: lat=%0d rdata=%h err=%b want 5 0000C35A 0",
                         lat, bus.cpu_rdata, bus.cpu_err);
    end
    n_checks++;
    if (slog.size() != 2 || slog[0] !== strobe_t'({8'hFD, 1'b0, 8'h00, 4'h3})
        || slog[1] !== strobe_t'({8'hFD, 1'b0, 8'h00, 4'h4})) begin
      n_fail++; $display("FAIL read2_strobes: n=%0d want 2 strobes on cs_n[1] with rw=0 regs 3,4",
                         slog.size());
    end
  endtask

  task automatic test_decode_err;
    int lat;
    do_access(1'b0, 8'h90, 2'd0, 32'h0, -1, lat);
    n_checks++;
    if (lat != 1 || bus.cpu_err !== 1'b1 || bus.cpu_rdata !== 32'h0 || slog.size() != 0) begin
      n_fail++; $display("FAIL err_slot: lat=%0d err=%b rdata=%h strobes=%0d want 1 1 0 0",
                         lat, bus.cpu_err, bus.cpu_rdata, slog.size());
    end
    do_access(1'b1, 8'h00, 2'd3, 32'h1234_5678, -1, lat);
    n_checks++;
    if (lat != 1 || bus.cpu_err !== 1'b1 || bus.cpu_rdata !== 32'h0 || slog.size() != 0) begin
      n_fail++; $display("FAIL err_size: lat=%0d err=%b rdata=%h strobes=%0d want 1 1 0 0",
                         lat, bus.cpu_err, bus.cpu_rdata, slog.size());
    end
    @(posedge sck); #1;
    n_checks++;
    if (bus.cpu_err !== 1'b1 || bus.cpu_busy !== 1'b0) begin
      n_fail++; $display("FAIL err_hold: err=%b busy=%b want 1 0", bus.cpu_err, bus.cpu_busy);
    end
  endtask

  task automatic test_ignored_req;
    int lat;
    int d0;
    d0 = done_cnt;
    do_access(1'b1, 8'h30, 2'd2, 32'hDEAD_BEEF, 3, lat);
    repeat (6) @(posedge sck);
    #1;
    n_checks++;
    if (lat != 9 || slog.size() != 4 || done_cnt - d0 != 1 || bus.cpu_busy !== 1'b0) begin
      n_fail++; $display("FAIL ignored_req: lat=%0d strobes=%0d dones=%0d busy=%b want 9 4 1 0",
                         lat, slog.size(), done_cnt - d0, bus.cpu_busy);
    end
  endtask

  task automatic test_mid_reset;
    int lat;
    int d0;
    d0 = done_cnt;
    slog.delete();
    @(posedge sck); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h00;
    bus.cpu_size = 2'd2; bus.cpu_wdata = 32'h7766_5544;
    @(posedge sck); #1;           // E0: accepted
    bus.cpu_req = 1'b0;
    @(posedge sck); #1;           // E0+1: first strobe
    @(posedge sck); #1;           // E0+2: second SETUP
    rst = 1'b1;
    @(posedge sck); #1;
    rst = 1'b0;
    n_checks++;
    if (bus.cs_n !== 8'hFF || bus.cpu_busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_bus: cs_n=%h busy=%b want FF 0", bus.cs_n, bus.cpu_busy);
    end
    repeat (10) @(posedge sck);
    #1;
    n_checks++;
    if (slog.size() != 1 || done_cnt != d0) begin
      n_fail++; $display("FAIL mid_reset_abort: strobes=%0d dones=%0d want 1 0",
                         slog.size(), done_cnt - d0);
    end
    do_access(1'b0, 8'h13, 2'd0, 32'h0, -1, lat);
    n_checks++;
    if (lat != 3 || bus.cpu_rdata !== 32'h0000_005A || bus.cpu_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_recover: lat=%0d rdata=%h err=%b want 3 0000005A 0",
                         lat, bus.cpu_rdata, bus.cpu_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) led_reg[i] = 8'h00;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00;
    bus.cpu_size = 2'd0; bus.cpu_wdata = 32'h0;
    test_reset();
    test_single_write();
    test_wrap_write();
    test_read();
    test_decode_err();
    test_ignored_req();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
